// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: bundles the HI/LO direct-write ports, the engine command
// and status signals, and the HI/LO read ports of hilo_muldiv.
//   w_en_1/w_hi_1/w_lo_1   slot-1 direct writes (w_en bit1 = HI, bit0 = LO)
//   w_en_2/w_hi_2/w_lo_2   slot-2 direct writes (younger, higher priority)
//   start/op/src_a/src_b   engine launch (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   cancel                 abort the in-flight engine operation
//   busy/done              engine status; done pulses in the result-write cycle
//   hi_r_data/lo_r_data    HI/LO read values
// master = the core driving the block, slave = hilo_muldiv itself.
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       w_en_1;
  logic [WIDTH-1:0] w_hi_1;
  logic [WIDTH-1:0] w_lo_1;
  logic [1:0]       w_en_2;
  logic [WIDTH-1:0] w_hi_2;
  logic [WIDTH-1:0] w_lo_2;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_r_data;
  logic [WIDTH-1:0] lo_r_data;

  modport master (
    output w_en_1, w_hi_1, w_lo_1, w_en_2, w_hi_2, w_lo_2,
    output start, op, src_a, src_b, cancel,
    input  busy, done, hi_r_data, lo_r_data
  );

  modport slave (
    input  w_en_1, w_hi_1, w_lo_1, w_en_2, w_hi_2, w_lo_2,
    input  start, op, src_a, src_b, cancel,
    output busy, done, hi_r_data, lo_r_data
  );
endinterface

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: HI/LO register pair with an iterative multiply/divide engine.
// Two issue slots write HI/LO directly; the engine runs MULT/MULTU/DIV/DIVU
// one bit per cycle (shift-add / restoring shift-subtract) on operand
// magnitudes, then sign-corrects and writes HI/LO in its FIN cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hilo_muldiv_if.slave (writes, engine command/status, reads)
// Parameters:
//   WIDTH  data width of HI, LO and operands
//   FWD    1: reads forward same-cycle pending writes; 0: registered only
module hilo_muldiv #(
  parameter int WIDTH = 32,
  parameter bit FWD   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  hilo_muldiv_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t             state, state_nxt;
  logic               busy, eng_we;

  logic [WIDTH-1:0]   hi_q, lo_q, hi_nxt, lo_nxt;

  // Engine registers. acc_q holds {partial product, multiplier} for a
  // multiply and {remainder, quotient/dividend} for a divide.
  logic               div_q;
  logic               neg_res_q;   // product/quotient must be negated
  logic               neg_rem_q;   // remainder takes the dividend's sign
  logic [WIDTH-1:0]   opnd_q;      // |multiplicand| or |divisor|
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [CW-1:0]      cnt_q;

  logic               signed_op, sign_a, sign_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   rem_cur, quo_cur;
  logic [WIDTH:0]     sum, shifted;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   eng_hi, eng_lo;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start && !bus.cancel) state_nxt = CALC;
      CALC: begin
        if (bus.cancel)                       state_nxt = IDLE;
        else if (cnt_q == CW'(WIDTH - 1))     state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // A cancel arriving in FIN suppresses both the write and the done pulse.
  always_comb begin
    busy   = (state != IDLE);
    eng_we = (state == FIN) && !bus.cancel;
  end

  // ---------------- operand preparation ----------------
  always_comb begin
    signed_op = ~bus.op[0];
    sign_a    = signed_op & bus.src_a[WIDTH-1];
    sign_b    = signed_op & bus.src_b[WIDTH-1];
    abs_a     = sign_a ? -bus.src_a : bus.src_a;
    abs_b     = sign_b ? -bus.src_b : bus.src_b;
  end

  // ---------------- one iteration ----------------
  assign rem_cur = acc_q[2*WIDTH-1:WIDTH];
  assign quo_cur = acc_q[WIDTH-1:0];

  always_comb begin
    sum      = {1'b0, rem_cur} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    shifted  = {rem_cur, quo_cur[WIDTH-1]};
    // When shifted >= divisor the true difference is below the divisor, so
    // the low WIDTH bits of a WIDTH-bit subtraction are exact.
    diff     = shifted[WIDTH-1:0] - opnd_q;
    acc_step = acc_q;
    if (!div_q)
      acc_step = {sum, quo_cur[WIDTH-1:1]};
    else if (shifted >= {1'b0, opnd_q})
      acc_step = {diff, quo_cur[WIDTH-2:0], 1'b1};
    else
      acc_step = {shifted[WIDTH-1:0], quo_cur[WIDTH-2:0], 1'b0};
  end

  // ---------------- engine datapath ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else if (state == IDLE) begin
      if (bus.start && !bus.cancel) begin
        div_q     <= bus.op[1];
        neg_res_q <= sign_a ^ sign_b;
        neg_rem_q <= sign_a;
        cnt_q     <= '0;
        if (bus.op[1]) begin
          opnd_q <= abs_b;
          acc_q  <= {{WIDTH{1'b0}}, abs_a};
        end else begin
          opnd_q <= abs_a;
          acc_q  <= {{WIDTH{1'b0}}, abs_b};
        end
      end
    end else if (state == CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // ---------------- result / sign correction ----------------
  // Divide by zero leaves the magnitude of the dividend in the remainder
  // and all ones in the quotient; re-applying the dividend's sign to the
  // remainder therefore returns src_a unchanged.
  always_comb begin
    prod = neg_res_q ? -acc_q : acc_q;
    if (!div_q) begin
      eng_hi = prod[2*WIDTH-1:WIDTH];
      eng_lo = prod[WIDTH-1:0];
    end else begin
      eng_hi = neg_rem_q ? -rem_cur : rem_cur;
      if (opnd_q == '0) eng_lo = '1;
      else              eng_lo = neg_res_q ? -quo_cur : quo_cur;
    end
  end

  // ---------------- HI/LO write priority: slot 2 > slot 1 > engine ----------------
  always_comb begin
    hi_nxt = hi_q;
    lo_nxt = lo_q;
    if (eng_we) begin
      hi_nxt = eng_hi;
      lo_nxt = eng_lo;
    end
    if (bus.w_en_1[1]) hi_nxt = bus.w_hi_1;
    if (bus.w_en_1[0]) lo_nxt = bus.w_lo_1;
    if (bus.w_en_2[1]) hi_nxt = bus.w_hi_2;
    if (bus.w_en_2[0]) lo_nxt = bus.w_lo_2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = eng_we;
  assign bus.hi_r_data = FWD ? hi_nxt : hi_q;
  assign bus.lo_r_data = FWD ? lo_nxt : lo_q;

endmodule
